// File: rtl/fir_mac_seq.sv
// fir_mac_seq
// Time-multiplexed FIR filter. It performs one multiply-accumulate per clock,
// so one output takes TAPS cycles. Coefficients can be programmed at run time.
// Samples enter through a valid/ready handshake. The accumulated sum is
// shifted right with rounding toward zero. It is then either saturated or
// wrapped to DW bits.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous reset, active-low
//   coef_we    : coefficient write strobe (honoured only when not in MAC)
//   coef_addr  : coefficient index, 0 = tap holding the newest sample
//   coef_din   : coefficient value (signed)
//   data_valid : input sample valid
//   data       : input sample (signed)
//   data_ready : block accepts a sample this cycle
//   fir_d      : filter output, 0 whenever fir_valid is low
//   fir_valid  : one-cycle output strobe
//   busy       : multiply-accumulate in progress
module fir_mac_seq #(
    parameter int DW     = 16,
    parameter int CW     = 16,
    parameter int TAPS   = 32,
    parameter int OSHIFT = 16,
    parameter int SAT    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [CW-1:0]           coef_din,
    input  logic                    data_valid,
    input  logic [DW-1:0]           data,
    output logic                    data_ready,
    output logic [DW-1:0]           fir_d,
    output logic                    fir_valid,
    output logic                    busy
);

    localparam int AW   = $clog2(TAPS);
    localparam int FW   = $clog2(TAPS + 1);
    localparam int PW   = DW + CW;
    localparam int ACCW = DW + CW + AW;

    localparam logic [AW:0]       TAPS_L   = (AW + 1)'(TAPS);
    localparam logic [AW-1:0]     LAST_IDX = AW'(TAPS - 1);
    localparam logic [FW-1:0]     FILL_MAX = FW'(TAPS);
    // Bits of the accumulator that the output shift discards.
    localparam logic [ACCW-1:0]   LO_MASK  = ~({ACCW{1'b1}} << OSHIFT);
    localparam logic signed [ACCW-1:0] OMAX = {{(ACCW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [ACCW-1:0] OMIN = {{(ACCW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic signed [DW-1:0]   tap_q  [TAPS];
    logic signed [DW-1:0]   tap_d  [TAPS];
    logic signed [CW-1:0]   coef_q [TAPS];
    logic signed [CW-1:0]   coef_d [TAPS];
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic                   fir_valid_q, fir_valid_d;
    logic [DW-1:0]          fir_d_q, fir_d_d;

    logic                   accept;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] prod_ext;
    logic signed [ACCW-1:0] shifted;
    logic                   round_up;
    logic signed [ACCW-1:0] rnd;
    logic [DW-1:0]          result;

    assign data_ready = (state_q != MAC);
    assign busy       = (state_q == MAC);
    assign fir_valid  = fir_valid_q;
    assign fir_d      = fir_d_q;
    assign accept     = data_valid && (state_q != MAC);

    // Datapath. Forms the product for the current tap, then the rounded and
    // limited output value from the finished accumulator. A negative sum that
    // loses nonzero bits in the shift is bumped up by one. This turns the
    // floor behaviour of >>> into truncation toward zero.
    always_comb begin
        prod     = tap_q[idx_q] * coef_q[idx_q];
        prod_ext = {{AW{prod[PW-1]}}, prod};
        shifted  = acc_q >>> OSHIFT;
        round_up = acc_q[ACCW-1] && (|(acc_q & LO_MASK));
        rnd      = shifted + {{(ACCW - 1){1'b0}}, round_up};
        result   = rnd[DW-1:0];
        if (SAT != 0) begin
            if (rnd > OMAX) begin
                result = OMAX[DW-1:0];
            end else if (rnd < OMIN) begin
                result = OMIN[DW-1:0];
            end
        end
    end

    // Next-state logic. A coefficient write is applied before a sample
    // accept, so a MAC that starts on the same edge sees the new value.
    // Writes are dropped during MAC so that one sum never mixes two
    // coefficient sets.
    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        coef_d      = coef_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        fill_d      = fill_q;
        fir_valid_d = 1'b0;
        fir_d_d     = '0;

        if (coef_we && (state_q != MAC) && ({1'b0, coef_addr} < TAPS_L)) begin
            coef_d[coef_addr] = coef_din;
        end

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            MAC: begin
                acc_d = acc_q + prod_ext;
                if (idx_q == LAST_IDX) begin
                    state_d = OUT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            OUT: begin
                // Outputs from a delay line that is not yet full are suppressed.
                if (fill_q == FILL_MAX) begin
                    fir_valid_d = 1'b1;
                    fir_d_d     = result;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            tap_d[0] = data;
            for (int i = 1; i < TAPS; i++) begin
                tap_d[i] = tap_q[i-1];
            end
            acc_d   = '0;
            idx_d   = '0;
            state_d = MAC;
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // State register. Reset clears the delay line, the coefficients and
    // any computation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            fill_q      <= '0;
            fir_valid_q <= 1'b0;
            fir_d_q     <= '0;
            for (int i = 0; i < TAPS; i++) begin
                tap_q[i]  <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            coef_q      <= coef_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            fill_q      <= fill_d;
            fir_valid_q <= fir_valid_d;
            fir_d_q     <= fir_d_d;
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// tb_fir_mac_seq
// Drives three filter instances from the same stimulus. Each instance has a
// different output setting: no shift with saturation, a 16-bit shift with
// saturation, and no shift with wrap. The reference model computes every
// accepted sample's full dot product at once. It then predicts the handshake
// and output timing from plain countdowns.
module tb_fir_mac_seq;

    localparam int TAPS = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        coef_we = 1'b0;
    logic [4:0]  coef_addr = '0;
    logic [15:0] coef_din = '0;
    logic        data_valid = 1'b0;
    logic [15:0] data = '0;

    logic        ready_a, ready_b, ready_c;
    logic        busy_a, busy_b, busy_c;
    logic        valid_a, valid_b, valid_c;
    logic [15:0] d_a, d_b, d_c;

    fir_mac_seq #(.DW(16), .CW(16), .TAPS(TAPS), .OSHIFT(0), .SAT(1)) u_a (
        .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_din(coef_din), .data_valid(data_valid), .data(data),
        .data_ready(ready_a), .fir_d(d_a), .fir_valid(valid_a), .busy(busy_a));

    fir_mac_seq #(.DW(16), .CW(16), .TAPS(TAPS), .OSHIFT(16), .SAT(1)) u_b (
        .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_din(coef_din), .data_valid(data_valid), .data(data),
        .data_ready(ready_b), .fir_d(d_b), .fir_valid(valid_b), .busy(busy_b));

    fir_mac_seq #(.DW(16), .CW(16), .TAPS(TAPS), .OSHIFT(0), .SAT(0)) u_c (
        .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_din(coef_din), .data_valid(data_valid), .data(data),
        .data_ready(ready_c), .fir_d(d_c), .fir_valid(valid_c), .busy(busy_c));

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;

    // Reference model state
    int     m_tap  [TAPS];
    int     m_coef [TAPS];
    int     m_fill;
    int     m_busy_cnt;
    int     m_out_cnt;
    bit     m_pend;
    longint m_pend_acc;
    bit     e_valid;
    longint e_acc;

    // Scales the true sum by 2^sh with truncation toward zero (integer
    // division), then saturates or keeps the low 16 bits.
    function automatic logic [15:0] shape(input longint acc, input int sh, input bit sat);
        longint      r;
        logic [63:0] rv;
        r = acc / (longint'(1) << sh);
        if (sat) begin
            if (r > 32767) r = 32767;
            else if (r < -32768) r = -32768;
        end
        rv = r;
        return rv[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) begin
            m_tap[i]  = 0;
            m_coef[i] = 0;
        end
        m_fill     = 0;
        m_busy_cnt = 0;
        m_out_cnt  = 0;
        m_pend     = 1'b0;
        m_pend_acc = 0;
        e_valid    = 1'b0;
        e_acc      = 0;
    endtask

    // Compares every output of all three instances with the model.
    task automatic checkOutput();
        logic        exp_ready;
        logic [15:0] ea, eb, ec;
        exp_ready = (m_busy_cnt == 0);
        ea = e_valid ? shape(e_acc, 0, 1'b1)  : 16'h0;
        eb = e_valid ? shape(e_acc, 16, 1'b1) : 16'h0;
        ec = e_valid ? shape(e_acc, 0, 1'b0)  : 16'h0;
        chk("a.data_ready", ready_a, exp_ready);
        chk("a.busy",       busy_a,  !exp_ready);
        chk("a.fir_valid",  valid_a, e_valid);
        chk("a.fir_d",      d_a,     ea);
        chk("b.data_ready", ready_b, exp_ready);
        chk("b.busy",       busy_b,  !exp_ready);
        chk("b.fir_valid",  valid_b, e_valid);
        chk("b.fir_d",      d_b,     eb);
        chk("c.data_ready", ready_c, exp_ready);
        chk("c.busy",       busy_c,  !exp_ready);
        chk("c.fir_valid",  valid_c, e_valid);
        chk("c.fir_d",      d_c,     ec);
    endtask

    // One clock: drive the inputs, advance the model at the edge, check 1ns later.
    task automatic applyStimulus(input bit v, input logic [15:0] d, input bit we,
                                 input logic [4:0] a, input logic [15:0] c,
                                 output bit accepted);
        bit     ready_before;
        longint sum;
        data_valid = v;
        data       = d;
        coef_we    = we;
        coef_addr  = a;
        coef_din   = c;
        @(posedge clk);
        ready_before = (m_busy_cnt == 0);
        if (m_busy_cnt > 0) m_busy_cnt--;
        e_valid = 1'b0;
        if (m_out_cnt > 0) begin
            m_out_cnt--;
            if (m_out_cnt == 0 && m_pend) begin
                e_valid = 1'b1;
                e_acc   = m_pend_acc;
            end
        end
        if (we && ready_before) m_coef[a] = $signed(c);
        accepted = v && ready_before;
        if (accepted) begin
            for (int i = TAPS - 1; i > 0; i--) m_tap[i] = m_tap[i-1];
            m_tap[0] = $signed(d);
            if (m_fill < TAPS) m_fill++;
            sum = 0;
            for (int i = 0; i < TAPS; i++) sum += longint'(m_tap[i]) * longint'(m_coef[i]);
            m_pend     = (m_fill >= TAPS);
            m_pend_acc = sum;
            m_out_cnt  = TAPS + 1;
            m_busy_cnt = TAPS;
        end
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) applyStimulus(1'b0, 16'h0, 1'b0, 5'd0, 16'h0, acc);
    endtask

    // Holds data_valid until the model says the sample was taken.
    task automatic send(input logic [15:0] d);
        bit acc;
        int n;
        n = 0;
        do begin
            applyStimulus(1'b1, d, 1'b0, 5'd0, 16'h0, acc);
            n++;
        end while (!acc && n < 100);
    endtask

    task automatic wcoef(input logic [4:0] a, input logic [15:0] c);
        bit acc;
        int n;
        n = 0;
        while (m_busy_cnt != 0 && n < 100) begin
            idle(1);
            n++;
        end
        applyStimulus(1'b0, 16'h0, 1'b1, a, c, acc);
    endtask

    initial begin
        bit acc;

        // Power-on reset
        model_reset();
        #3;
        checkOutput();
        @(posedge clk);
        #1;
        rst = 1'b1;

        $display("[TB] impulse");
        for (int i = 0; i < TAPS; i++) wcoef(5'(i), 16'(i + 1));
        for (int i = 0; i < TAPS - 1; i++) send(16'h0000);
        send(16'h0001);
        for (int i = 0; i < 8; i++) send(16'h0000);
        idle(40);

        $display("[TB] back-to-back handshake");
        for (int i = 0; i < 5; i++) send(16'($urandom));
        idle(40);

        $display("[TB] coefficient write during MAC");
        send(16'h0000);
        idle(5);
        applyStimulus(1'b0, 16'h0, 1'b1, 5'd0, 16'd5, acc);
        idle(40);
        send(16'h0001);
        idle(40);
        wcoef(5'd0, 16'd5);
        send(16'h0000);
        send(16'h0001);
        idle(40);

        $display("[TB] rounding");
        for (int i = 0; i < TAPS; i++) wcoef(5'(i), 16'd1);
        for (int i = 0; i < 29; i++) send(16'h0000);
        send(16'h8000); send(16'h8000); send(16'hFFFF);
        for (int i = 0; i < 30; i++) send(16'h0000);
        send(16'h8000); send(16'h8000);
        for (int i = 0; i < 29; i++) send(16'h0000);
        send(16'h7FFF); send(16'h7FFF); send(16'h0003);
        idle(40);

        $display("[TB] saturation");
        for (int i = 0; i < TAPS; i++) wcoef(5'(i), 16'h7FFF);
        for (int i = 0; i < TAPS; i++) send(16'h7FFF);
        for (int i = 0; i < TAPS; i++) send(16'h8001);
        for (int i = 0; i < TAPS; i++) send(16'h8000);
        idle(40);

        $display("[TB] reset during MAC");
        send(16'h1234);
        idle(10);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        checkOutput();
        @(posedge clk);
        #1;
        checkOutput();
        rst = 1'b1;
        idle(40);
        for (int i = 0; i < TAPS; i++) wcoef(5'(i), 16'(i + 1));
        for (int i = 0; i < TAPS + 2; i++) send(16'($urandom));
        idle(40);

        $display("[TB] randomized traffic");
        for (int i = 0; i < TAPS; i++) wcoef(5'(i), 16'($urandom));
        for (int i = 0; i < 2500; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 16'($urandom),
                          $urandom_range(0, 3) == 0, 5'($urandom),
                          16'($urandom), acc);
        end
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
